// File: rtl/rl_lj_pair_gen.sv
// rl_lj_pair_gen: source end of the LJ pair-evaluation stream.
// Walks every (home, neighbour) combination of one cell pair. For each pair it emits dx, dy, dz
// (home minus neighbour) and r2 = dx*dx + dy*dy + dz*dz in IEEE single precision, one pair per
// cycle within a home row, with no backpressure.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset (aborts a sweep, no done)
//   start_i                    one-cycle pulse, accepted only when idle
//   home_count_i, nb_count_i   particle counts, latched when start is accepted
//   home_rd_*/nb_rd_*          1-cycle-latency position RAM ports, data packed as {z,y,x}
//   r2_valid_o, r2_o, dx_o, dy_o, dz_o, id_home_o, id_nb_o
//                              pair output; data holds its last value while r2_valid_o is low
//   busy_o                     high from the cycle after start acceptance until before done
//   done_o                     one-cycle pulse at sweep completion
//
// Timing (start sampled in cycle 0, H/N = home/nb counts):
//   neighbour read for pair (r, k) issues in cycle 3 + r*(N+2) + k, its output is valid 18
//   cycles later; done is high in cycle H*(N+2) + 19, so the sweep spans H*(N+2) + 20 cycles
//   counting both the start and done cycles. With H == 0 or N == 0 done is high in cycle 1.
//
// Optional feature (macro PAIR_CUTOFF_FILTER_EN): pairs with r2 == 0 or r2 > CUTOFF_2 are not
// presented (r2_valid_o stays low) and are counted on filtered_count_o, cleared on start.
//
// Arithmetic: normal numbers only (subnormals flush to zero), round to nearest even. Each FP
// operation is evaluated on entry to its pipeline stage; the following registers balance the
// stage to the fixed operator latency (sub 3, mul 4, mul-add 5). The mul-add is an unfused
// multiply followed by an add.
module rl_lj_pair_gen #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] CUTOFF_2   = 32'h43100000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ID_WIDTH:0]       home_count_i,
  input  logic [ID_WIDTH:0]       nb_count_i,
  output logic                    home_rd_en_o,
  output logic [ID_WIDTH-1:0]     home_rd_addr_o,
  input  logic [3*DATA_WIDTH-1:0] home_rd_data_i,
  output logic                    nb_rd_en_o,
  output logic [ID_WIDTH-1:0]     nb_rd_addr_o,
  input  logic [3*DATA_WIDTH-1:0] nb_rd_data_i,
  output logic                    r2_valid_o,
  output logic [DATA_WIDTH-1:0]   r2_o,
  output logic [DATA_WIDTH-1:0]   dx_o,
  output logic [DATA_WIDTH-1:0]   dy_o,
  output logic [DATA_WIDTH-1:0]   dz_o,
  output logic [ID_WIDTH-1:0]     id_home_o,
  output logic [ID_WIDTH-1:0]     id_nb_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef PAIR_CUTOFF_FILTER_EN
  ,
  output logic [2*ID_WIDTH:0]     filtered_count_o
`endif
);

  localparam int unsigned PIPE_LATENCY = 18;
  localparam int unsigned LastStage    = PIPE_LATENCY - 1;
  localparam int unsigned MulXStage    = 5;   // dx*dx enters here (issue + 4)
  localparam int unsigned AddYStage    = 9;   // dy*dy + acc enters here (issue + 8)
  localparam int unsigned AddZStage    = 14;  // dz*dz + acc enters here (issue + 13)

  // ---------------------------------------------------------------- FP helpers (binary32)
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s, g, st;
    logic [47:0]        p;
    logic [23:0]        m;
    logic signed [10:0] e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (p[47]) begin
      m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; e = e + 11'sd1;
    end else begin
      m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin m = 24'd0; e = e + 11'sd1; end  // rounded up to the next binade
    if (e <= 11'sd0) return {s, 31'd0};
    if (e >= 11'sd255) return {s, 8'hff, 23'd0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x, y;
    logic [26:0]        mx, my, sh;
    logic [27:0]        sum;
    logic [7:0]         d;
    logic [23:0]        m;
    logic               g, st;
    logic signed [10:0] e;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end else begin x = b; y = a; end
    if (x[30:23] == 8'd0) return 32'd0;
    if (y[30:23] == 8'd0) return x;
    mx = {1'b1, x[22:0], 3'b000};  // hidden bit, fraction, guard/round/sticky
    my = {1'b1, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    if (d > 8'd26) begin
      sh = 27'd1;
    end else begin
      sh = my >> d;
      if ((my & ~({27{1'b1}} << d)) != 27'd0) sh[0] = 1'b1;
    end
    e = $signed({3'b000, x[30:23]});
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, sh};
      if (sum[27]) begin sum = {1'b0, sum[27:2], sum[1] | sum[0]}; e = e + 11'sd1; end
    end else begin
      sum = {1'b0, mx} - {1'b0, sh};
      if (sum == 28'd0) return 32'd0;
      for (int k = 0; k < 26; k++) begin
        if (!sum[26]) begin sum = sum << 1; e = e - 11'sd1; end
      end
    end
    m = {1'b0, sum[25:3]}; g = sum[2]; st = |sum[1:0];
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin m = 24'd0; e = e + 11'sd1; end
    if (e <= 11'sd0) return 32'd0;
    if (e >= 11'sd255) return {x[31], 8'hff, 23'd0};
    return {x[31], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    return fp_add(a, {~b[31], b[30:0]});
  endfunction

  // ---------------------------------------------------------------- sweep FSM
  typedef enum logic [2:0] {StIdle, StLoadHome, StWaitHome, StStream, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH:0]       home_cnt_q, home_cnt_d, nb_cnt_q, nb_cnt_d;
  logic [ID_WIDTH-1:0]     i_q, i_d, j_q, j_d;
  logic [3*DATA_WIDTH-1:0] home_q, home_d;
  logic                    start_acc, pipe_busy, last_nb, last_home;

  assign last_nb   = ({1'b0, j_q} == nb_cnt_q - 1'b1);
  assign last_home = ({1'b0, i_q} == home_cnt_q - 1'b1);

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    home_cnt_d   = home_cnt_q;
    nb_cnt_d     = nb_cnt_q;
    home_d       = home_q;
    start_acc    = 1'b0;
    home_rd_en_o = 1'b0;
    nb_rd_en_o   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          start_acc  = 1'b1;
          home_cnt_d = home_count_i;
          nb_cnt_d   = nb_count_i;
          i_d        = '0;
          j_d        = '0;
          state_d    = (home_count_i == '0 || nb_count_i == '0) ? StDone : StLoadHome;
        end
      end
      StLoadHome: begin
        home_rd_en_o = 1'b1;
        state_d      = StWaitHome;
      end
      // Previous row's last neighbour is consumed by the subtract stage one cycle earlier,
      // so the home registers are free to be overwritten here.
      StWaitHome: begin
        home_d  = home_rd_data_i;
        j_d     = '0;
        state_d = StStream;
      end
      StStream: begin
        nb_rd_en_o = 1'b1;
        j_d        = j_q + 1'b1;
        if (last_nb) begin
          if (last_home) begin
            state_d = StDrain;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = StLoadHome;
          end
        end
      end
      StDrain: if (!pipe_busy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      home_cnt_q <= '0;
      nb_cnt_q   <= '0;
      i_q        <= '0;
      j_q        <= '0;
      home_q     <= '0;
    end else begin
      state_q    <= state_d;
      home_cnt_q <= home_cnt_d;
      nb_cnt_q   <= nb_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      home_q     <= home_d;
    end
  end

  assign home_rd_addr_o = i_q;
  assign nb_rd_addr_o   = j_q;
  assign busy_o         = (state_q != StIdle) && (state_q != StDone);
  assign done_o         = (state_q == StDone);

  // ---------------------------------------------------------------- datapath pipeline
  typedef struct packed {
    logic                  vld;
    logic [ID_WIDTH-1:0]   ih;
    logic [ID_WIDTH-1:0]   in;
    logic [DATA_WIDTH-1:0] dx;
    logic [DATA_WIDTH-1:0] dy;
    logic [DATA_WIDTH-1:0] dz;
    logic [DATA_WIDTH-1:0] acc;
  } stage_t;

  // Stage s holds the pair whose neighbour read issued s cycles earlier.
  logic                s1_vld_q;
  logic [ID_WIDTH-1:0] s1_ih_q, s1_in_q;
  stage_t              pipe_q [LastStage:2];
  stage_t              pipe_d [LastStage:2];

  always_comb begin
    pipe_d[2].vld = s1_vld_q;
    pipe_d[2].ih  = s1_ih_q;
    pipe_d[2].in  = s1_in_q;
    pipe_d[2].dx  = fp_sub(home_q[DATA_WIDTH-1:0], nb_rd_data_i[DATA_WIDTH-1:0]);
    pipe_d[2].dy  = fp_sub(home_q[2*DATA_WIDTH-1:DATA_WIDTH],
                           nb_rd_data_i[2*DATA_WIDTH-1:DATA_WIDTH]);
    pipe_d[2].dz  = fp_sub(home_q[3*DATA_WIDTH-1:2*DATA_WIDTH],
                           nb_rd_data_i[3*DATA_WIDTH-1:2*DATA_WIDTH]);
    pipe_d[2].acc = '0;
    for (int s = 3; s <= LastStage; s++) pipe_d[s] = pipe_q[s-1];
    pipe_d[MulXStage].acc = fp_mul(pipe_q[MulXStage-1].dx, pipe_q[MulXStage-1].dx);
    pipe_d[AddYStage].acc = fp_add(fp_mul(pipe_q[AddYStage-1].dy, pipe_q[AddYStage-1].dy),
                                   pipe_q[AddYStage-1].acc);
    pipe_d[AddZStage].acc = fp_add(fp_mul(pipe_q[AddZStage-1].dz, pipe_q[AddZStage-1].dz),
                                   pipe_q[AddZStage-1].acc);
  end

  always_comb begin
    pipe_busy = s1_vld_q;
    for (int s = 2; s <= LastStage; s++) pipe_busy = pipe_busy | pipe_q[s].vld;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q <= 1'b0;
      s1_ih_q  <= '0;
      s1_in_q  <= '0;
      for (int s = 2; s <= LastStage; s++) pipe_q[s] <= '0;
    end else begin
      s1_vld_q <= nb_rd_en_o;
      s1_ih_q  <= i_q;
      s1_in_q  <= j_q;
      for (int s = 2; s <= LastStage; s++) pipe_q[s] <= pipe_d[s];
    end
  end

  // ---------------------------------------------------------------- output stage
  logic emit;

`ifdef PAIR_CUTOFF_FILTER_EN
  logic               cut;
  logic [2*ID_WIDTH:0] filt_q;

  // r2 is never negative, so its bit pattern orders like an unsigned integer.
  assign cut  = (pipe_q[LastStage].acc > CUTOFF_2) || (pipe_q[LastStage].acc == '0);
  assign emit = pipe_q[LastStage].vld && !cut;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           filt_q <= '0;
    else if (start_acc)                    filt_q <= '0;
    else if (pipe_q[LastStage].vld && cut) filt_q <= filt_q + 1'b1;
  end
  assign filtered_count_o = filt_q;
`else
  logic unused_cutoff;
  assign unused_cutoff = ^CUTOFF_2 ^ start_acc;
  assign emit          = pipe_q[LastStage].vld;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r2_valid_o <= 1'b0;
      r2_o       <= '0;
      dx_o       <= '0;
      dy_o       <= '0;
      dz_o       <= '0;
      id_home_o  <= '0;
      id_nb_o    <= '0;
    end else begin
      r2_valid_o <= emit;
      if (emit) begin
        r2_o      <= pipe_q[LastStage].acc;
        dx_o      <= pipe_q[LastStage].dx;
        dy_o      <= pipe_q[LastStage].dy;
        dz_o      <= pipe_q[LastStage].dz;
        id_home_o <= pipe_q[LastStage].ih;
        id_nb_o   <= pipe_q[LastStage].in;
      end
    end
  end

endmodule
